// File: rtl/ttt_pkg.sv
// ttt_pkg: shared definitions for the N x N, K-in-a-row board engine.
//   - cell codes stored two bits per board cell
//   - game state encoding (also driven out on game_state)
//   - scan direction codes and their row/column step lookup
package ttt_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_CHECK = 3'd2,
    ST_WIN   = 3'd3,
    ST_DRAW  = 3'd4
  } game_state_e;

  localparam logic [1:0] DIR_HORIZ = 2'd0;  // (dr,dc) = (0, 1)
  localparam logic [1:0] DIR_VERT  = 2'd1;  // (dr,dc) = (1, 0)
  localparam logic [1:0] DIR_DIAG  = 2'd2;  // (dr,dc) = (1, 1)  down-right
  localparam logic [1:0] DIR_ANTI  = 2'd3;  // (dr,dc) = (1,-1)  down-left

  function automatic logic signed [1:0] dir_dr(input logic [1:0] dir);
    logic signed [1:0] dr;
    dr = (dir == DIR_HORIZ) ? 2'sd0 : 2'sd1;
    return dr;
  endfunction

  function automatic logic signed [1:0] dir_dc(input logic [1:0] dir);
    logic signed [1:0] dc;
    case (dir)
      DIR_HORIZ: dc = 2'sd1;
      DIR_VERT:  dc = 2'sd0;
      DIR_DIAG:  dc = 2'sd1;
      default:   dc = -2'sd1;
    endcase
    return dc;
  endfunction

endpackage

// File: rtl/ttt_line_scan.sv
// ttt_line_scan: sequential K-in-a-row detector run after each accepted move.
// Visits one cell per cycle, directions 0..3 in order, steps
// -(WIN_LEN-1)..+(WIN_LEN-1) around the origin, counting the current run of
// the mover's code.
// Ports:
//   clk, rst          clock, async active-high reset
//   go                latch origin/mover and start scanning
//   abort             stop an active scan (game cleared)
//   board             live board vector, 2 bits per cell
//   org_row, org_col  placed cell, sampled on go
//   mover             code of the player who moved, sampled on go
//   done              high on the last scan cycle (win found or all steps done)
//   found             with done: a run of WIN_LEN was seen
//   dir               direction being scanned (winning one when found)
//   end_row, end_col  cell being visited (last cell of the run when found)
module ttt_line_scan
  import ttt_pkg::*;
#(
  parameter int N       = 3,
  parameter int WIN_LEN = 3,
  localparam int RW     = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic                 abort,
  input  logic [2*N*N-1:0]     board,
  input  logic [RW-1:0]        org_row,
  input  logic [RW-1:0]        org_col,
  input  logic [1:0]           mover,
  output logic                 done,
  output logic                 found,
  output logic [1:0]           dir,
  output logic [RW-1:0]        end_row,
  output logic [RW-1:0]        end_col
);

  // Two extra bits keep negative and >= N coordinates distinct from legal ones.
  localparam int SW  = RW + 2;
  localparam int RNW = $clog2(WIN_LEN + 1);
  localparam int BW  = $clog2(2 * N * N);
  localparam logic signed [SW-1:0] K_MAX   = SW'(WIN_LEN - 1);
  localparam logic signed [SW-1:0] K_MIN   = -K_MAX;
  localparam logic signed [SW-1:0] N_S     = SW'(N);
  localparam logic [RNW-1:0]       RUN_WIN = RNW'(WIN_LEN);

  logic                 active_q, active_d;
  logic [1:0]           dir_q, dir_d;
  logic signed [SW-1:0] k_q, k_d;
  logic [RNW-1:0]       run_q, run_d;
  logic signed [SW-1:0] org_r_q, org_r_d, org_c_q, org_c_d;
  logic [1:0]           mover_q, mover_d;

  logic signed [SW-1:0] dr_s, dc_s, cur_r, cur_c;
  logic                 on_board, match;
  logic [BW-1:0]        bit_idx;

  always_comb begin
    dr_s     = SW'(dir_dr(dir_q));
    dc_s     = SW'(dir_dc(dir_q));
    cur_r    = org_r_q + k_q * dr_s;
    cur_c    = org_c_q + k_q * dc_s;
    on_board = !cur_r[SW-1] && !cur_c[SW-1] && (cur_r < N_S) && (cur_c < N_S);
    bit_idx  = on_board ? BW'(2 * (int'(cur_r) * N + int'(cur_c))) : '0;
    match    = on_board && (board[bit_idx +: 2] == mover_q);
  end

  always_comb begin
    active_d = active_q;
    dir_d    = dir_q;
    k_d      = k_q;
    run_d    = run_q;
    org_r_d  = org_r_q;
    org_c_d  = org_c_q;
    mover_d  = mover_q;
    done     = 1'b0;
    found    = 1'b0;
    if (abort) begin
      active_d = 1'b0;
    end else if (go) begin
      active_d = 1'b1;
      dir_d    = DIR_HORIZ;
      k_d      = K_MIN;
      run_d    = '0;
      org_r_d  = {2'b00, org_row};
      org_c_d  = {2'b00, org_col};
      mover_d  = mover;
    end else if (active_q) begin
      run_d = match ? run_q + RNW'(1) : '0;
      if (match && (run_q + RNW'(1) == RUN_WIN)) begin
        done     = 1'b1;
        found    = 1'b1;
        active_d = 1'b0;
      end else if (k_q == K_MAX) begin
        run_d = '0;
        k_d   = K_MIN;
        if (dir_q == DIR_ANTI) begin
          done     = 1'b1;
          active_d = 1'b0;
        end else begin
          dir_d = dir_q + 2'd1;
        end
      end else begin
        k_d = k_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      dir_q    <= '0;
      k_q      <= '0;
      run_q    <= '0;
      org_r_q  <= '0;
      org_c_q  <= '0;
      mover_q  <= CELL_EMPTY;
    end else begin
      active_q <= active_d;
      dir_q    <= dir_d;
      k_q      <= k_d;
      run_q    <= run_d;
      org_r_q  <= org_r_d;
      org_c_q  <= org_c_d;
      mover_q  <= mover_d;
    end
  end

  assign dir     = dir_q;
  assign end_row = cur_r[RW-1:0];
  assign end_col = cur_c[RW-1:0];

endmodule

// File: rtl/ttt_board_engine.sv
// ttt_board_engine: N x N, WIN_LEN-in-a-row game engine. Owns board, turn,
// move count and game state; runs ttt_line_scan after every accepted move.
// Ports:
//   clk, rst                  clock, async active-high reset
//   start, clear              new game / back to main screen (clear wins)
//   move_valid, move_row/col  move request from the keypad front end
//   move_ready, busy          high in PLAY / CHECK
//   move_reject               one-cycle pulse after an illegal request
//   board                     cell i=r*N+c at [2i+1:2i]; 00 empty, 01 X, 10 O
//   turn_o                    0 = X to move, 1 = O to move
//   game_state                ttt_pkg::game_state_e encoding
//   winner, draw              result of the finished game
//   win_dir, win_row/col      direction and last cell of the winning run
//   move_count                accepted moves this game
//
// state | meaning
// IDLE  | main screen, waiting for start
// PLAY  | waiting for the current player's move
// CHECK | line scan running on the cell just placed
// WIN   | mover completed a run; board frozen
// DRAW  | board full without a run; board frozen
module ttt_board_engine
  import ttt_pkg::*;
#(
  parameter int N       = 3,
  parameter int WIN_LEN = 3,
  localparam int RW     = $clog2(N),
  localparam int CW     = $clog2(N * N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic             move_valid,
  input  logic [RW-1:0]    move_row,
  input  logic [RW-1:0]    move_col,
  output logic             move_ready,
  output logic             move_reject,
  output logic             busy,
  output logic [2*N*N-1:0] board,
  output logic             turn_o,
  output logic [2:0]       game_state,
  output logic [1:0]       winner,
  output logic             draw,
  output logic [1:0]       win_dir,
  output logic [RW-1:0]    win_row,
  output logic [RW-1:0]    win_col,
  output logic [CW-1:0]    move_count
);

  localparam int BW = $clog2(2 * N * N);
  localparam logic [RW:0]   N_W  = (RW + 1)'(N);
  localparam logic [CW-1:0] FULL = CW'(N * N);

  game_state_e      state_q, state_d;
  logic [2*N*N-1:0] board_q, board_d;
  logic             turn_q, turn_d;
  logic [CW-1:0]    count_q, count_d;
  logic [1:0]       winner_q, winner_d;
  logic             draw_q, draw_d;
  logic [1:0]       win_dir_q, win_dir_d;
  logic [RW-1:0]    win_row_q, win_row_d, win_col_q, win_col_d;
  logic             reject_q, reject_d;

  logic             scan_go, scan_done, scan_found;
  logic [1:0]       scan_dir;
  logic [RW-1:0]    scan_row, scan_col;
  logic [1:0]       mover;
  logic             in_range, legal, new_game;
  logic [BW-1:0]    mv_idx;

  assign mover = turn_q ? CELL_O : CELL_X;

  ttt_line_scan #(.N(N), .WIN_LEN(WIN_LEN)) u_scan (
    .clk     (clk),
    .rst     (rst),
    .go      (scan_go),
    .abort   (clear),
    .board   (board_q),
    .org_row (move_row),
    .org_col (move_col),
    .mover   (mover),
    .done    (scan_done),
    .found   (scan_found),
    .dir     (scan_dir),
    .end_row (scan_row),
    .end_col (scan_col)
  );

  always_comb begin
    in_range = ({1'b0, move_row} < N_W) && ({1'b0, move_col} < N_W);
    mv_idx   = in_range ? BW'(2 * (int'(move_row) * N + int'(move_col))) : '0;
    legal    = in_range && (board_q[mv_idx +: 2] == CELL_EMPTY);
    new_game = start && (state_q inside {ST_IDLE, ST_WIN, ST_DRAW});
  end

  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    turn_d    = turn_q;
    count_d   = count_q;
    winner_d  = winner_q;
    draw_d    = draw_q;
    win_dir_d = win_dir_q;
    win_row_d = win_row_q;
    win_col_d = win_col_q;
    reject_d  = 1'b0;
    scan_go   = 1'b0;
    if (clear || new_game) begin
      state_d   = clear ? ST_IDLE : ST_PLAY;
      board_d   = '0;
      turn_d    = 1'b0;
      count_d   = '0;
      winner_d  = CELL_EMPTY;
      draw_d    = 1'b0;
      win_dir_d = '0;
      win_row_d = '0;
      win_col_d = '0;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (move_valid) begin
            if (!legal) begin
              reject_d = 1'b1;
            end else begin
              board_d[mv_idx +: 2] = mover;
              count_d              = count_q + CW'(1);
              scan_go              = 1'b1;
              state_d              = ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (scan_done) begin
            if (scan_found) begin
              winner_d  = mover;
              win_dir_d = scan_dir;
              win_row_d = scan_row;
              win_col_d = scan_col;
              state_d   = ST_WIN;
            end else if (count_q == FULL) begin
              draw_d  = 1'b1;
              state_d = ST_DRAW;
            end else begin
              turn_d  = ~turn_q;
              state_d = ST_PLAY;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      board_q   <= '0;
      turn_q    <= 1'b0;
      count_q   <= '0;
      winner_q  <= CELL_EMPTY;
      draw_q    <= 1'b0;
      win_dir_q <= '0;
      win_row_q <= '0;
      win_col_q <= '0;
      reject_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      turn_q    <= turn_d;
      count_q   <= count_d;
      winner_q  <= winner_d;
      draw_q    <= draw_d;
      win_dir_q <= win_dir_d;
      win_row_q <= win_row_d;
      win_col_q <= win_col_d;
      reject_q  <= reject_d;
    end
  end

  assign move_ready  = (state_q == ST_PLAY);
  assign busy        = (state_q == ST_CHECK);
  assign move_reject = reject_q;
  assign board       = board_q;
  assign turn_o      = turn_q;
  assign game_state  = state_q;
  assign winner      = winner_q;
  assign draw        = draw_q;
  assign win_dir     = win_dir_q;
  assign win_row     = win_row_q;
  assign win_col     = win_col_q;
  assign move_count  = count_q;

endmodule

// File: doc/ttt_board_engine.md
Name: ttt_board_engine

Overview:
Parametrised N×N, K-in-a-row game engine; successor to the fixed 3×3 tic-tac-toe board/turn logic. Accepts decoded moves from the keypad front end and owns the board, turn, move count and game state. Runs a sequential win/draw check after each accepted move. Feeds the board vector to the dot-matrix driver and status to the 7-segment driver.

Parameters:
N, 3, board side length; legal 3..8
WIN_LEN, 3, contiguous stones required to win; legal 3..N
RW, $clog2(N), row/col index width (localparam)
CW, $clog2(N*N+1), move counter width (localparam)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse: new game
clear  in  1  one-cycle pulse: return to main screen
move_valid  in  1  one-cycle pulse: move request
move_row  in  RW  target row
move_col  in  RW  target column
move_ready  out  1  high only in PLAY
move_reject  out  1  one-cycle pulse: illegal move
busy  out  1  high in CHECK
board  out  2*N*N  cell i=r*N+c at bits [2i+1:2i]; 00 empty, 01 X, 10 O
turn_o  out  1  0 = X to move, 1 = O to move
game_state  out  3  IDLE/PLAY/CHECK/WIN/DRAW encoding
winner  out  2  00 none, 01 X, 10 O
draw  out  1  high in DRAW
win_dir  out  2  0 horiz, 1 vert, 2 diag (down-right), 3 anti-diag (down-left)
win_row, win_col  out  RW each  last cell of winning run
move_count  out  CW  accepted moves this game

Behaviour:
- Reset (async, immediate): state IDLE, board 0, turn_o 0, winner 00, draw 0, win_dir/win_row/win_col 0, move_count 0, move_reject 0.
- Priority per cycle: rst > clear > start > move_valid.
- clear in any state: board 0, counters/flags 0, turn_o 0, -> IDLE next cycle.
- start in IDLE, WIN, or DRAW: board 0, move_count 0, winner 00, draw 0, turn_o 0 (X first), -> PLAY. Ignored in PLAY and CHECK.
- PLAY, move_valid:
  - row>=N, col>=N, or cell non-empty -> move_reject high exactly next cycle; board and turn unchanged.
  - Else write current player's code, move_count+1, -> CHECK on next edge.
- move_valid outside PLAY: ignored, no reject.
- CHECK: one cell per cycle, directions 0..3 in order. For each direction (dr,dc) = (0,1), (1,0), (1,1), (1,-1), k steps -(WIN_LEN-1)..+(WIN_LEN-1) around the placed cell (r+k·dr, c+k·dc).
  - Off-board cell or cell not equal to mover's code -> run=0.
  - Match -> run+1.
  - run==WIN_LEN -> latch winner=mover, win_dir=d, win_row/win_col=current cell, -> WIN next cycle (early exit).
  - Scan done without win: move_count==N*N -> DRAW; else toggle turn_o, -> PLAY.
  - Max CHECK length 4·(2·WIN_LEN-1) cycles (20 for defaults); busy high throughout.
- WIN/DRAW: board frozen, turn_o held; only start/clear act.
- Arithmetic: signed scan coordinates RW+2 bits wide, so negative and ≥N coordinates are detected as off-board without wrap-around.
- move_reject is registered and never high two cycles from one request.

Decomposition:
- Package ttt_pkg:
  - cell codes CELL_EMPTY/CELL_X/CELL_O
  - state encoding IDLE=0, PLAY=1, CHECK=2, WIN=3, DRAW=4
  - direction codes and dr/dc lookup function
- Sub-module ttt_line_scan: the CHECK sequencer. Takes board, origin, mover code, go pulse; returns done, found, dir, end row/col. The top keeps the game FSM, board register, and turn/count logic.

Test Plan:
1. Reset, then start -> board=0, game_state=PLAY, turn_o=0, move_ready=1, move_count=0; async rst mid-CHECK -> all outputs at reset values before next clk edge.
2. X(0,0) O(1,0) X(0,1) O(1,1) X(0,2) -> WIN, winner=01, win_dir=0, win_row=0, win_col=2, move_count=5; CHECK lasted ≤20 cycles.
3. X(1,1) then O(1,1) -> move_reject one cycle, board cell 4 stays 01, turn_o remains 1; O(3,0) also rejected.
4. X00 O01 X02 O11 X10 O12 X21 O20 X22 -> DRAW, draw=1, winner=00, move_count=9; further move_valid ignored, no reject.
5. X02 O00 X11 O01 X20 -> winner=01, win_dir=3, win_row=2, win_col=0.
6. clear and start asserted same cycle in WIN -> IDLE, board=0; N=4 WIN_LEN=3: X(0,1) X(1,2) X(2,3) with O elsewhere -> win_dir=2, win_row=2, win_col=3.
